// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA pipeline: count width and
// the 800x600 @ 60 Hz default geometry.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 11;

    localparam int unsigned DEF_H_ACTIVE     = 800;
    localparam int unsigned DEF_H_TOTAL      = 1056;
    localparam int unsigned DEF_H_SYNC_START = 840;
    localparam int unsigned DEF_H_SYNC_WIDTH = 128;
    localparam int unsigned DEF_V_ACTIVE     = 600;
    localparam int unsigned DEF_V_TOTAL      = 628;
    localparam int unsigned DEF_V_SYNC_START = 601;
    localparam int unsigned DEF_V_SYNC_WIDTH = 4;

    // Half-open window test lo <= x < hi on unsigned counts.
    function automatic logic in_window(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter with blanking/sync flags decoded from
// the next count so flags stay aligned with the registered count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned TOTAL      = DEF_H_TOTAL,
    parameter int unsigned SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned SYNC_WIDTH = DEF_H_SYNC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             blnk,
    output logic             sync,
    output logic             wrap_c
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(SYNC_START + SYNC_WIDTH);

    logic [CNT_W-1:0] count_nxt_c;

    assign wrap_c      = step && (count == LAST);
    assign count_nxt_c = wrap_c ? '0 : count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= 1'b0;
        end else if (clear) begin
            count <= '0;
            blnk  <= 1'b0;
            sync  <= 1'b0;
        end else if (step) begin
            count <= count_nxt_c;
            blnk  <= (count_nxt_c >= ACT_END);
            sync  <= in_window(count_nxt_c, SYNC_LO, SYNC_HI);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source: horizontal axis steps every enabled
// clock, vertical axis steps on the horizontal wrap, frame_start marks (0,0).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_WIDTH = DEF_H_SYNC_WIDTH,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_WIDTH = DEF_V_SYNC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic             frame_start
);

    logic h_wrap_c;
    logic v_wrap_c;
    logic v_step_c;

    vga_axis_counter #(
        .ACTIVE     (H_ACTIVE),
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_SYNC_START),
        .SYNC_WIDTH (H_SYNC_WIDTH)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (en),
        .clear  (1'b0),
        .count  (hcount_out),
        .blnk   (hblnk_out),
        .sync   (hsync_out),
        .wrap_c (h_wrap_c)
    );

    assign v_step_c = h_wrap_c & en;

    vga_axis_counter #(
        .ACTIVE     (V_ACTIVE),
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_SYNC_START),
        .SYNC_WIDTH (V_SYNC_WIDTH)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (v_step_c),
        .clear  (1'b0),
        .count  (vcount_out),
        .blnk   (vblnk_out),
        .sync   (vsync_out),
        .wrap_c (v_wrap_c)
    );

    // Vertical wrap only fires on an enabled last-pixel edge, so this is the (0,0) pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= v_wrap_c;
        end
    end

endmodule
